cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Parametrised capture block that sits beside the CPU core and records its observable outputs (Temp, Finalextend, ReadData1, ReadData2, Zero) cycle by cycle into an internal circular buffer. Recording is armed, kept in a pre-trigger window until a programmable match on Temp occurs, and then completes a fixed post-trigger window. The frozen trace is drained oldest-first over a valid/ready port. It extends the fixed-width, free-running CPU bench with generic width, depth, triggering and a readout handshake.

## Interface
- DATA_W, 16, width of each CPU output word
- DEPTH, 16, buffer entries; power of two, minimum 4
- PRE_TRIG, 4, pre-trigger samples kept; 0 ≤ PRE_TRIG ≤ DEPTH-1
- Clk  in  1  rising-edge clock shared with the CPU
- Reset_n  in  1  reset, synchronous and active-low
- Arm  in  1  pulse; start or restart a capture
- Force_trig  in  1  trigger unconditionally this cycle
- Trig_mask  in  DATA_W  bits of Temp to compare; all-zero means the first armed sample triggers
- Trig_value  in  DATA_W  compare value
- Temp, Finalextend, ReadData1, ReadData2  in  DATA_W each  CPU sample inputs
- Zero  in  1  CPU flag sample
- Rd_ready  in  1  consumer accepts Rd_data
- Rd_valid  out  1  Rd_data holds an unread entry
- Rd_data  out  4*DATA_W+1  {Zero, ReadData2, ReadData1, Finalextend, Temp}
- Rd_stamp  out  16  cycle stamp of the entry (see Configuration)
- Rd_last  out  1  current entry is the final one
- Count  out  log2(DEPTH)+1  entries captured in the frozen trace
- State  out  2  IDLE=0, PRE=1, POST=2, DONE=3
- Done  out  1  State==DONE

## Operation
- IDLE: no capture. Arm → PRE; this clears wr_ptr and pre_cnt.
- PRE: every cycle writes the sample at mem[wr_ptr], then wr_ptr++ modulo DEPTH. pre_cnt saturates at PRE_TRIG.
- Trigger condition: Force_trig, or ((Temp ^ Trig_value) & Trig_mask) == 0. It is evaluated on the same sample being written. Trigger in PRE:
  - the trigger sample is written;
  - start_ptr = wr_ptr - pre_cnt (mod DEPTH);
  - post_left = DEPTH-PRE_TRIG-1;
  - Count = pre_cnt + DEPTH - PRE_TRIG;
  - if post_left==0, go straight to DONE; otherwise go to POST.
- POST: writes one sample per cycle and decrements post_left. The write that takes post_left to 0 goes to DONE. The trigger condition is ignored.
- DONE: the buffer is frozen.
  - Rd_data is read combinationally from mem[rd_ptr], with rd_ptr starting at start_ptr.
  - Rd_valid=1 while unread entries remain.
  - A transfer occurs when Rd_valid && Rd_ready; it advances rd_ptr (mod DEPTH).
  - Rd_last=1 on entry Count-1. The transfer of that entry returns the block to IDLE, with Rd_valid low the next cycle.
- Trace order: pre-trigger samples oldest first. The trigger sample is at index pre_cnt, followed by the post-trigger samples.
- Arm in any state, including POST or mid-readout in DONE, restarts the capture in PRE. Any partial trace is discarded, and the sample on the Arm cycle is not captured.
- Arm together with a trigger condition: Arm wins. Triggering is evaluated from the next cycle.
- Trigger before PRE_TRIG samples exist: only pre_cnt samples precede the trigger, and Count < DEPTH.
- Rd_ready while Rd_valid=0 has no effect. Rd_valid never drops without a transfer, except on Arm or reset.

## Timing
- Capture latency: a sample presented in cycle n is stored at the rising edge ending cycle n.
- State changes on the same edge as the triggering write.
- DONE is first visible in the cycle after the last POST write. Rd_valid rises in that same cycle, with zero added latency.
- Readout rate: one entry per cycle while Rd_ready is held high.
- Reset (Reset_n=0 at a rising edge), including mid-capture or mid-readout:
  - State=IDLE; Done=0, Rd_valid=0, Rd_last=0, Count=0;
  - Rd_data is don't-care, Rd_stamp=0;
  - pointers, counters and stamp are cleared. Memory contents need not be cleared.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - a 16-bit cycle counter clears on Arm and increments every cycle in PRE and POST, wrapping at 0xFFFF→0;
  - each entry stores the counter value in a parallel 16-bit memory;
  - Rd_stamp presents the stamp of the current entry.
- Not defined: no counter and no stamp memory; Rd_stamp is tied to 0. All other behaviour is identical.

## Test plan
Bench parameters: DEPTH=16, PRE_TRIG=4.
- Mask-match trigger: Reset_n low for 2 cycles, then Arm. Drive Temp=cycle index 0..30. Trig_mask=0xFFFF, Trig_value=10 → Count=16, Done=1. The drain yields Temp 6..21, with Rd_last on 21 and IDLE after it.
- Early trigger: Arm, then Force_trig on the 2nd armed sample (Temp=1) → Count=13. The drain yields Temp 0..12, with the trigger sample at index 1.
- Backpressure: Rd_ready toggled 1,0,0,1,… → every entry is transferred exactly once, in order. Rd_data is stable while Rd_ready=0.
- Re-arm and reset: Arm pulsed mid-POST → State=PRE and Count=0 the next cycle, and the old trace never appears. Reset_n low mid-readout → Rd_valid=0 and State=0 the next cycle.
- Immediate trigger: Trig_mask=0 → triggers on the first armed sample. Count=12, and the drain starts at that sample.
- With TRACE_TIMESTAMP_EN defined, the mask-match run → Rd_stamp sequence 6..21. Without the macro, Rd_stamp stays 0 throughout.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: capture controls, CPU sample inputs and trace readout port of cpu_trace_buffer
interface cpu_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  logic                     Arm;
  logic                     Force_trig;
  logic [DATA_W-1:0]        Trig_mask;
  logic [DATA_W-1:0]        Trig_value;
  logic [DATA_W-1:0]        Temp;
  logic [DATA_W-1:0]        Finalextend;
  logic [DATA_W-1:0]        ReadData1;
  logic [DATA_W-1:0]        ReadData2;
  logic                     Zero;
  logic                     Rd_ready;
  logic                     Rd_valid;
  logic [4*DATA_W:0]        Rd_data;
  logic [15:0]              Rd_stamp;
  logic                     Rd_last;
  logic [$clog2(DEPTH):0]   Count;
  logic [1:0]               State;
  logic                     Done;
  modport master (
    output Arm, Force_trig, Trig_mask, Trig_value, Temp, Finalextend, ReadData1, ReadData2, Zero, Rd_ready,
    input  Rd_valid, Rd_data, Rd_stamp, Rd_last, Count, State, Done
  );
  modport slave (
    input  Arm, Force_trig, Trig_mask, Trig_value, Temp, Finalextend, ReadData1, ReadData2, Zero, Rd_ready,
    output Rd_valid, Rd_data, Rd_stamp, Rd_last, Count, State, Done
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: armed pre/post-trigger capture of CPU outputs into a circular buffer, drained oldest-first.
// Defining TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp per entry on Rd_stamp; otherwise Rd_stamp is 0.
module cpu_trace_buffer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int PRE_TRIG = 4
) (
  input logic               Clk,
  input logic               Reset_n,
  cpu_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4*DATA_W+1;
  localparam logic [AW-1:0] PT     = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_N = AW'(DEPTH-PRE_TRIG-1);
  localparam logic [AW:0]   BASE   = (AW+1)'(DEPTH-PRE_TRIG);
  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_left_q, post_left_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   rd_idx_q, rd_idx_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic          trig, we, valid, last, xfer;
  assign trig  = bus.Force_trig || ((bus.Temp ^ bus.Trig_value) & bus.Trig_mask) == '0;
  assign we    = (state_q == PRE || state_q == POST) && !bus.Arm;
  assign valid = state_q == DONE;
  assign last  = rd_idx_q == count_q - 1'b1;
  assign xfer  = valid && bus.Rd_ready;
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_left_q <= '0;
      count_q     <= '0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_left_q <= post_left_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
    end
  end
  // Arm overrides everything, including a coincident trigger or an in-flight readout
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_left_d = post_left_q;
    count_d     = count_q;
    rd_idx_d    = rd_idx_q;
    if (bus.Arm) begin
      state_d   = PRE;
      wr_ptr_d  = '0;
      pre_cnt_d = '0;
      count_d   = '0;
      rd_idx_d  = '0;
    end else if (state_q == PRE) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (trig) begin
        rd_ptr_d    = wr_ptr_q - pre_cnt_q;
        post_left_d = POST_N;
        count_d     = {1'b0, pre_cnt_q} + BASE;
        rd_idx_d    = '0;
        state_d     = POST_N == '0 ? DONE : POST;
      end else begin
        pre_cnt_d = pre_cnt_q == PT ? PT : pre_cnt_q + 1'b1;
      end
    end else if (state_q == POST) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      post_left_d = post_left_q - 1'b1;
      state_d     = post_left_q == AW'(1) ? DONE : POST;
    end else if (xfer) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rd_idx_d = rd_idx_q + 1'b1;
      state_d  = last ? IDLE : DONE;
    end
  end
  always_ff @(posedge Clk) begin
    if (we) mem_q[wr_ptr_q] <= {bus.Zero, bus.ReadData2, bus.ReadData1, bus.Finalextend, bus.Temp};
  end
  assign bus.Rd_valid = valid;
  assign bus.Rd_data  = mem_q[rd_ptr_q];
  assign bus.Rd_last  = valid && last;
  assign bus.Count    = count_q;
  assign bus.State    = state_q;
  assign bus.Done     = valid;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] stamp_q [DEPTH];
  always_ff @(posedge Clk) begin
    if (!Reset_n) ts_q <= '0;
    else ts_q <= bus.Arm ? '0 : (state_q == PRE || state_q == POST) ? ts_q + 1'b1 : ts_q;
  end
  always_ff @(posedge Clk) begin
    if (we) stamp_q[wr_ptr_q] <= ts_q;
  end
  assign bus.Rd_stamp = valid ? stamp_q[rd_ptr_q] : '0;
`else
  assign bus.Rd_stamp = '0;
`endif
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed scenarios for cpu_trace_buffer with DEPTH=16, PRE_TRIG=4
module tb_cpu_trace_buffer;
  logic clk = 0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  cpu_trace_buffer_if #(.DATA_W(16), .DEPTH(16)) bus();
  cpu_trace_buffer #(.DATA_W(16), .DEPTH(16), .PRE_TRIG(4)) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .bus(bus.slave)
  );
  function automatic logic [64:0] exp_data(input logic [15:0] t);
    logic [15:0] f, r2;
    f  = t + 16'h0100;
    r2 = 16'(t * 16'd3);
    return {t[0], r2, ~t, f, t};
  endfunction
  task automatic drive(input logic [15:0] t);
    bus.Temp        = t;
    bus.Finalextend = t + 16'h0100;
    bus.ReadData1   = ~t;
    bus.ReadData2   = 16'(t * 16'd3);
    bus.Zero        = t[0];
  endtask
  task automatic arm(input string nm);
    bus.Arm        = 1;
    bus.Force_trig = 1;
    drive(16'hBEEF);
    @(negedge clk);
    bus.Arm        = 0;
    bus.Force_trig = 0;
    n_chk++;
    if (bus.State !== 2'd1) begin n_fail++; $display("FAIL %s arm_state got %0d want 1", nm, bus.State); end
    n_chk++;
    if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL %s arm_count got %0d want 0", nm, bus.Count); end
    n_chk++;
    if (bus.Rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s arm_valid got %b want 0", nm, bus.Rd_valid); end
  endtask
  task automatic feed(input logic [15:0] base, input int force_k, input int max_k);
    for (int k = 0; k < max_k && !bus.Done; k++) begin
      drive(base + 16'(k));
      bus.Force_trig = (k == force_k);
      @(negedge clk);
    end
    bus.Force_trig = 0;
  endtask
  task automatic capture(input string nm, input logic [15:0] base, input logic [15:0] mask,
                         input logic [15:0] value, input int force_k, input logic [4:0] exp_cnt);
    bus.Trig_mask  = mask;
    bus.Trig_value = value;
    arm(nm);
    feed(base, force_k, 40);
    n_chk++;
    if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL %s done got %b want 1", nm, bus.Done); end
    n_chk++;
    if (bus.State !== 2'd3) begin n_fail++; $display("FAIL %s state got %0d want 3", nm, bus.State); end
    n_chk++;
    if (bus.Count !== exp_cnt) begin n_fail++; $display("FAIL %s count got %0d want %0d", nm, bus.Count, exp_cnt); end
  endtask
  task automatic drain(input string nm, input logic [15:0] base, input int first_k, input int n,
                       input int max_n, input bit bp);
    int idx = 0;
    int c = 0;
    logic [15:0] exp_st;
    while (idx < max_n && c < 200) begin
      bus.Rd_ready = bp ? (c % 3 == 0) : 1'b1;
      n_chk++;
      if (bus.Rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s valid idx %0d got %b want 1", nm, idx, bus.Rd_valid);
        break;
      end
      n_chk++;
      if (bus.Rd_data !== exp_data(base + 16'(first_k + idx)))
        begin n_fail++; $display("FAIL %s data idx %0d got %h want %h", nm, idx, bus.Rd_data, exp_data(base + 16'(first_k + idx))); end
      n_chk++;
      if (bus.Rd_last !== (idx == n - 1)) begin n_fail++; $display("FAIL %s last idx %0d got %b want %b", nm, idx, bus.Rd_last, idx == n - 1); end
`ifdef TRACE_TIMESTAMP_EN
      exp_st = 16'(first_k + idx);
`else
      exp_st = 16'd0;
`endif
      n_chk++;
      if (bus.Rd_stamp !== exp_st) begin n_fail++; $display("FAIL %s stamp idx %0d got %0d want %0d", nm, idx, bus.Rd_stamp, exp_st); end
      if (bus.Rd_ready) idx++;
      @(negedge clk);
      c++;
    end
    bus.Rd_ready = 0;
    n_chk++;
    if (idx != max_n) begin n_fail++; $display("FAIL %s drained got %0d want %0d", nm, idx, max_n); end
  endtask
  task automatic check_idle(input string nm);
    n_chk++;
    if (bus.Rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s idle_valid got %b want 0", nm, bus.Rd_valid); end
    n_chk++;
    if (bus.State !== 2'd0) begin n_fail++; $display("FAIL %s idle_state got %0d want 0", nm, bus.State); end
    n_chk++;
    if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL %s idle_done got %b want 0", nm, bus.Done); end
  endtask
  task automatic test_reset;
    rst_n          = 0;
    bus.Arm        = 0;
    bus.Force_trig = 0;
    bus.Rd_ready   = 0;
    bus.Trig_mask  = '0;
    bus.Trig_value = '0;
    drive(16'h0);
    repeat (2) @(negedge clk);
    check_idle("reset");
    n_chk++;
    if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL reset count got %0d want 0", bus.Count); end
    n_chk++;
    if (bus.Rd_last !== 1'b0) begin n_fail++; $display("FAIL reset last got %b want 0", bus.Rd_last); end
    n_chk++;
    if (bus.Rd_stamp !== 16'd0) begin n_fail++; $display("FAIL reset stamp got %0d want 0", bus.Rd_stamp); end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_mask_match;
    capture("mask", 16'd0, 16'hFFFF, 16'd10, -1, 5'd16);
    drain("mask", 16'd0, 6, 16, 16, 1'b0);
    check_idle("mask_end");
  endtask
  task automatic test_early_trigger;
    capture("early", 16'd0, 16'hFFFF, 16'hFFFF, 1, 5'd13);
    drain("early", 16'd0, 0, 13, 13, 1'b0);
    check_idle("early_end");
  endtask
  task automatic test_backpressure;
    capture("bp", 16'd300, 16'hFFFF, 16'd310, -1, 5'd16);
    drain("bp", 16'd300, 6, 16, 16, 1'b1);
    check_idle("bp_end");
  endtask
  task automatic test_rearm;
    bus.Trig_mask  = 16'hFFFF;
    bus.Trig_value = 16'd10;
    arm("rearm0");
    feed(16'd0, -1, 15);
    n_chk++;
    if (bus.State !== 2'd2) begin n_fail++; $display("FAIL rearm mid_state got %0d want 2", bus.State); end
    capture("rearm", 16'd100, 16'hFFFF, 16'd110, -1, 5'd16);
    drain("rearm", 16'd100, 6, 16, 16, 1'b0);
    check_idle("rearm_end");
  endtask
  task automatic test_reset_readout;
    capture("rstrd", 16'd200, 16'hFFFF, 16'd210, -1, 5'd16);
    drain("rstrd", 16'd200, 6, 16, 3, 1'b0);
    rst_n = 0;
    @(negedge clk);
    check_idle("rstrd_after");
    n_chk++;
    if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL rstrd count got %0d want 0", bus.Count); end
    rst_n = 1;
    @(negedge clk);
    check_idle("rstrd_release");
  endtask
  task automatic test_immediate;
    capture("imm", 16'd500, 16'h0000, 16'h1234, -1, 5'd12);
    drain("imm", 16'd500, 0, 12, 12, 1'b0);
    check_idle("imm_end");
  endtask
  initial begin
    test_reset();
    test_mask_match();
    test_early_trigger();
    test_backpressure();
    test_rearm();
    test_reset_readout();
    test_immediate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
